// File: rtl/pio_poll_sequencer.sv
// Polls a 4-bit input PIO over Avalon-MM, debounces the samples and latches stable
// values with per-bit edge capture and a level interrupt for the CPU-facing slave.
module pio_poll_sequencer #(
  parameter int WIDTH          = 4,
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1000,
  parameter int DEBOUNCE       = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STABLE = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;
  localparam logic [3:0] DEB         = 4'(DEBOUNCE);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;

  state_t              r_state;
  logic                r_m_read;
  logic [PERIOD_W-1:0] r_cnt;
  logic [1:0]          r_ctrl;
  logic [PERIOD_W-1:0] r_period;
  logic [WIDTH-1:0]    r_stable;
  logic [WIDTH-1:0]    r_prev;
  logic [3:0]          r_match;
  logic [WIDTH-1:0]    r_edge;
  logic [31:0]         r_rdata;
  logic                r_irq;

  logic [PERIOD_W-1:0] w_reload;
  logic [WIDTH-1:0]    w_sample;
  logic [3:0]          w_match_nxt;
  logic                w_stable_upd;
  logic [WIDTH-1:0]    w_edge_set;
  logic [WIDTH-1:0]    w_edge_clr;
  logic [WIDTH-1:0]    w_edge_nxt;
  logic [1:0]          w_ctrl_nxt;
  logic [31:0]         w_rd_data;
  logic                w_unused;

  assign m_address  = 2'b00;
  assign m_read     = r_m_read;
  assign s_readdata = r_rdata;
  assign irq        = r_irq;
  assign w_unused   = ^{m_readdata[31:WIDTH], s_writedata[31:PERIOD_W]};

  // Periods below 3 clamp to the minimum IDLE/ISSUE/CAPTURE round trip.
  assign w_reload = (r_period < PERIOD_W'(3)) ? '0 : r_period - PERIOD_W'(3);
  assign w_sample = m_readdata[WIDTH-1:0];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_match_nxt  = 4'd1;
    w_stable_upd = 1'b0;
    w_edge_set   = '0;
    w_edge_clr   = '0;
    w_ctrl_nxt   = r_ctrl;
    w_rd_data    = '0;

    if (w_sample == r_prev)
      w_match_nxt = (r_match >= DEB) ? DEB : r_match + 4'd1;
    if (r_state == ST_CAPTURE && w_match_nxt >= DEB && w_sample != r_stable)
      w_stable_upd = 1'b1;
    if (w_stable_upd)
      w_edge_set = w_sample ^ r_stable;

    if (s_write && s_address == ADDR_EDGE)
      w_edge_clr = s_writedata[WIDTH-1:0];
    if (s_write && s_address == ADDR_CTRL)
      w_ctrl_nxt = s_writedata[1:0];

    case (s_address)
      ADDR_CTRL:   w_rd_data = 32'(r_ctrl);
      ADDR_PERIOD: w_rd_data = 32'(r_period);
      ADDR_STABLE: w_rd_data = 32'(r_stable);
      default:     w_rd_data = 32'(r_edge);
    endcase
  end

  // NOTE: a capture setting an EDGE bit overrides a W1C of that bit in the same cycle.
  assign w_edge_nxt = (r_edge & ~w_edge_clr) | w_edge_set;

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_m_read <= 1'b0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_prev   <= '0;
      r_match  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_m_read <= 1'b0;
          if (!r_ctrl[0]) begin
            r_cnt <= w_reload;
          end else if (r_cnt == '0) begin
            r_state  <= ST_ISSUE;
            r_m_read <= 1'b1;
          end else begin
            r_cnt <= r_cnt - PERIOD_W'(1);
          end
        end
        ST_ISSUE: begin
          r_m_read <= 1'b0;
          r_state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_cnt   <= w_reload;
          r_state <= ST_IDLE;
          r_prev  <= w_sample;
          r_match <= w_match_nxt;
          if (w_stable_upd)
            r_stable <= w_sample;
        end
        default: begin
          r_m_read <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_period <= PERIOD_W'(DEFAULT_PERIOD);
      r_edge   <= '0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      r_edge <= w_edge_nxt;
      r_irq  <= w_ctrl_nxt[1] & (|w_edge_nxt);
      if (s_write && s_address == ADDR_PERIOD)
        r_period <= s_writedata[PERIOD_W-1:0];
      if (s_read)
        r_rdata <= w_rd_data;
    end
  end

endmodule

// File: doc/pio_poll_sequencer.md
Name: pio_poll_sequencer

Overview:
- Avalon-MM controller that sequences the 4-bit input PIO used for the car's sensor and switch inputs.
- Issues periodic reads to the PIO's data register and debounces the sampled value over consecutive polls.
- Latches the debounced value and records per-bit changes in an edge-capture register, with an optional interrupt.
- Exposes a small CPU-facing Avalon-MM slave, so the Nios core no longer has to poll the PIO in software.

Parameters:
WIDTH, 4, number of PIO input bits used (readdata[WIDTH-1:0]).
PERIOD_W, 16, width of the poll-period register.
DEFAULT_PERIOD, 1000, reset value of PERIOD, in clocks.
DEBOUNCE, 3, number of consecutive identical samples required before STABLE updates (1..15).

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
m_address  out  2  PIO register address; always 0.
m_read  out  1  one-cycle read strobe to the PIO.
m_readdata  in  32  PIO readdata; registered there, valid the cycle after m_read.
s_address  in  2  CPU register select.
s_read  in  1  CPU read strobe.
s_write  in  1  CPU write strobe.
s_writedata  in  32  CPU write data.
s_readdata  out  32  CPU read data; registered, latency 1.
irq  out  1  level interrupt = CTRL.irq_en & |EDGE; registered.

Behaviour:
- Reset (synchronous) sets:
  - state IDLE, m_read=0, m_address=0;
  - CTRL=0, PERIOD=DEFAULT_PERIOD;
  - STABLE=0, prev_sample=0, match_cnt=0, EDGE=0;
  - s_readdata=0, irq=0.
  Reset mid-poll abandons the read; no capture takes place.
- Register map (unused bits read 0):
  - 0 CTRL: bit0 enable, bit1 irq_en; read/write.
  - 1 PERIOD: bits [PERIOD_W-1:0]; read/write.
  - 2 STABLE: bits [WIDTH-1:0]; read-only, writes ignored.
  - 3 EDGE: bits [WIDTH-1:0]; a write of 1 clears that bit (W1C).
- Slave reads: s_readdata loads the selected register in the cycle s_read is sampled and holds otherwise. Slave writes take effect on the next clock edge. There is no waitrequest.
- Reload value: R = max(PERIOD,3) - 3. Any PERIOD below 3 behaves as 3.
- FSM:
  - IDLE: while enable=0, cnt is held at R. While enable=1, cnt decrements each cycle; with cnt==0 the FSM moves to ISSUE.
  - ISSUE: m_read=1 for exactly one cycle; then CAPTURE.
  - CAPTURE: s = m_readdata[WIDTH-1:0]; cnt <= R; then IDLE.
  - Result: m_read pulses exactly max(PERIOD,3) cycles apart.
- Debounce in CAPTURE:
  - If s != prev_sample: prev_sample <= s, match_cnt <= 1.
  - Otherwise: match_cnt <= min(match_cnt+1, DEBOUNCE).
  - When the new match_cnt >= DEBOUNCE and s != STABLE: STABLE <= s and EDGE <= EDGE | (s ^ STABLE).
  - DEBOUNCE=1 means STABLE follows every sample.
- Simultaneous events:
  - An EDGE set and a CPU W1C on the same bit in the same cycle leaves the bit set (set wins).
  - Clearing enable during ISSUE or CAPTURE lets the in-flight poll complete, including its capture; the FSM then stays in IDLE.
  - A PERIOD write takes effect at the next reload (CAPTURE or while disabled); the current countdown is not disturbed.
- Startup: STABLE starts at 0, so inputs already high at enable produce edges after DEBOUNCE polls. This is intended behaviour.
- m_readdata bits above WIDTH-1 are ignored.

Test Plan:
- Reset, then PERIOD=10, CTRL=1 -> m_read is a single-cycle pulse every 10 clocks with m_address=0; PERIOD=1 gives pulses every 3 clocks.
- PIO=4'b0101 held, DEBOUNCE=3, CTRL=3 -> STABLE=5 after the 3rd capture, EDGE=5, irq=1; write EDGE=4'b0001 -> EDGE=4, irq stays 1; write EDGE=4 -> irq=0.
- PIO glitch pattern 5,5,0,5,5 over polls (STABLE=0 initially) -> STABLE stays 0 until the capture completing 3 consecutive 5s. Any run shorter than DEBOUNCE never updates STABLE.
- STABLE=5 with EDGE bit0 clearing write landing on the same cycle as a capture that changes STABLE to 4 -> EDGE bit0 reads 1 (set wins), bit2 unaffected by the write.
- Clear enable on the ISSUE cycle -> the capture still occurs, no further m_read pulses; re-enable -> first pulse max(PERIOD,3)-2 cycles later. Assert reset during CAPTURE -> all registers return to their reset values.
- Write PERIOD=20 mid-countdown at PERIOD=10 -> the current interval stays 10 and subsequent intervals are 20; s_readdata for address 1 reads 20 one cycle after s_read.
